// File: rtl/block_accumulator.sv
// block_accumulator: requests a block of DEPTH products, returns their unsigned sum and maximum
// through a valid/ready handshake. Rev 1.0
`default_nettype none

module block_accumulator #(
    parameter int N     = 32,
    parameter int DEPTH = 64,
    parameter int ACC_W = N + $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    output logic             EN_blockRead,
    input  logic             VALID_memVal,
    input  logic [N-1:0]     memVal_data,
    output logic             VALID_result,
    input  logic             RDY_result,
    output logic [ACC_W-1:0] RESULT_sum,
    output logic [N-1:0]     RESULT_max,
    output logic             BUSY,
    output logic             ERR_stray
);

    localparam int CNT_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ACCUM = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  beat_cnt;
    logic [ACC_W-1:0]  acc;
    logic [N-1:0]      run_max;
    logic [ACC_W-1:0]  acc_next;
    logic [N-1:0]      max_next;
    logic              beat_take;
    logic              last_beat;

    assign beat_take = VALID_memVal && (state == REQ || state == ACCUM);
    assign last_beat = beat_take && (state == ACCUM) && (beat_cnt == LAST_BEAT);
    assign acc_next  = acc + {{(ACC_W-N){1'b0}}, memVal_data};
    assign max_next  = (memVal_data > run_max) ? memVal_data : run_max;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        EN_blockRead = 1'b0;
        VALID_result = 1'b0;
        BUSY         = 1'b1;
        case (state)
            IDLE: begin
                BUSY = 1'b0;
                if (START) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                EN_blockRead = 1'b1;
                if (VALID_memVal) begin
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                EN_blockRead = 1'b1;
                if (last_beat) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                VALID_result = 1'b1;
                if (RDY_result) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            beat_cnt   <= '0;
            acc        <= '0;
            run_max    <= '0;
            RESULT_sum <= '0;
            RESULT_max <= '0;
            ERR_stray  <= 1'b0;
        end else begin
            if (state == IDLE && START) begin
                beat_cnt <= '0;
                acc      <= '0;
                run_max  <= '0;
            end else if (beat_take) begin
                beat_cnt <= beat_cnt + 1'b1;
                acc      <= acc_next;
                run_max  <= max_next;
            end
            // Result registers load only on block completion so they hold across the next block.
            if (last_beat) begin
                RESULT_sum <= acc_next;
                RESULT_max <= max_next;
            end
            if (VALID_memVal && (state == IDLE || state == HOLD)) begin
                ERR_stray <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_block_accumulator.sv
// tb_block_accumulator: directed self-checking bench for block_accumulator.
`default_nettype none

module tb_block_accumulator;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic        EN_blockRead;
    logic        VALID_memVal;
    logic [31:0] memVal_data;
    logic        VALID_result;
    logic        RDY_result;
    logic [37:0] RESULT_sum;
    logic [31:0] RESULT_max;
    logic        BUSY;
    logic        ERR_stray;

    int total = 0;
    int bad   = 0;

    block_accumulator #(.N(32), .DEPTH(64)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .START        (START),
        .EN_blockRead (EN_blockRead),
        .VALID_memVal (VALID_memVal),
        .memVal_data  (memVal_data),
        .VALID_result (VALID_result),
        .RDY_result   (RDY_result),
        .RESULT_sum   (RESULT_sum),
        .RESULT_max   (RESULT_max),
        .BUSY         (BUSY),
        .ERR_stray    (ERR_stray)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_block();
        START = 1'b1;
        step();
        START = 1'b0;
        check("en_after_start", 64'(EN_blockRead), 64'd1);
        check("busy_after_start", 64'(BUSY), 64'd1);
    endtask

    // n contiguous beats of constant value; EN_blockRead and VALID_result checked before each edge
    task automatic beats(input int n, input logic [31:0] v);
        int en_low = 0;
        int vr_hi  = 0;
        for (int i = 0; i < n; i++) begin
            if (EN_blockRead !== 1'b1) en_low++;
            if (VALID_result !== 1'b0) vr_hi++;
            VALID_memVal = 1'b1;
            memVal_data  = v;
            step();
        end
        VALID_memVal = 1'b0;
        memVal_data  = '0;
        check("en_low_during_beats", 64'(en_low), 64'd0);
        check("early_valid_result", 64'(vr_hi), 64'd0);
    endtask

    task automatic expect_result(input string tag, input logic [37:0] s, input logic [31:0] m);
        check({tag, "_valid"}, 64'(VALID_result), 64'd1);
        check({tag, "_en_off"}, 64'(EN_blockRead), 64'd0);
        check({tag, "_sum"}, 64'(RESULT_sum), 64'(s));
        check({tag, "_max"}, 64'(RESULT_max), 64'(m));
    endtask

    task automatic handshake();
        RDY_result = 1'b1;
        step();
        RDY_result = 1'b0;
        check("hs_valid_drop", 64'(VALID_result), 64'd0);
        check("hs_idle", 64'(BUSY), 64'd0);
    endtask

    initial begin
        logic [31:0] vals [3];
        int          gap_err;
        vals[0] = 32'd5;
        vals[1] = 32'd3;
        vals[2] = 32'd9;

        RST_N        = 1'b0;
        START        = 1'b0;
        VALID_memVal = 1'b0;
        memVal_data  = '0;
        RDY_result   = 1'b0;
        #2;
        check("rst_en", 64'(EN_blockRead), 64'd0);
        check("rst_valid", 64'(VALID_result), 64'd0);
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_err", 64'(ERR_stray), 64'd0);
        check("rst_sum", 64'(RESULT_sum), 64'd0);
        check("rst_max", 64'(RESULT_max), 64'd0);
        step();
        step();
        RST_N = 1'b1;
        step();

        // Block 1: data 1..64
        start_block();
        for (int i = 1; i <= 64; i++) begin
            check("en_ramp", 64'(EN_blockRead), 64'd1);
            VALID_memVal = 1'b1;
            memVal_data  = 32'(i);
            step();
        end
        VALID_memVal = 1'b0;
        expect_result("ramp", 38'd2080, 32'd64);
        handshake();
        check("ramp_sum_retained", 64'(RESULT_sum), 64'd2080);

        // Block 2: saturating data, sum must not overflow
        start_block();
        beats(64, 32'hFFFF_FFFF);
        expect_result("allones", 38'h3F_FFFF_FFC0, 32'hFFFF_FFFF);
        handshake();

        // Block 3: 5,3,9 then 61 x 4 with random gaps; sum = 17 + 244 = 261
        start_block();
        gap_err = 0;
        for (int i = 0; i < 64; i++) begin
            int g;
            g = $urandom_range(1, 4);
            for (int k = 0; k < g; k++) begin
                step();
                if (EN_blockRead !== 1'b1 || VALID_result !== 1'b0) gap_err++;
            end
            VALID_memVal = 1'b1;
            memVal_data  = (i < 3) ? vals[i] : 32'd4;
            step();
            VALID_memVal = 1'b0;
        end
        check("gap_state_held", 64'(gap_err), 64'd0);
        expect_result("gaps", 38'd261, 32'd9);
        gap_err = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (VALID_result !== 1'b1 || RESULT_sum !== 38'd261 || RESULT_max !== 32'd9) gap_err++;
        end
        check("hold_stable_10", 64'(gap_err), 64'd0);
        handshake();

        // Block 4: asynchronous abort after 30 beats, then a clean block of 2s
        start_block();
        beats(30, 32'd9);
        #3;
        RST_N = 1'b0;
        #1;
        check("abort_en", 64'(EN_blockRead), 64'd0);
        check("abort_busy", 64'(BUSY), 64'd0);
        check("abort_valid", 64'(VALID_result), 64'd0);
        check("abort_sum", 64'(RESULT_sum), 64'd0);
        check("abort_max", 64'(RESULT_max), 64'd0);
        check("abort_err", 64'(ERR_stray), 64'd0);
        #2;
        RST_N = 1'b1;
        step();
        start_block();
        beats(64, 32'd2);
        expect_result("after_abort", 38'd128, 32'd2);
        handshake();

        // Block 5: stray beat in IDLE, START pulses ignored during ACCUM
        VALID_memVal = 1'b1;
        memVal_data  = 32'd1000;
        step();
        VALID_memVal = 1'b0;
        check("stray_set", 64'(ERR_stray), 64'd1);
        start_block();
        beats(10, 32'd1);
        START = 1'b1;
        beats(1, 32'd1);
        START = 1'b0;
        beats(10, 32'd1);
        START = 1'b1;
        beats(1, 32'd1);
        START = 1'b0;
        beats(41, 32'd1);
        check("no_early_close", 64'(VALID_result), 64'd0);
        beats(1, 32'd1);
        expect_result("stray", 38'd64, 32'd1);
        check("stray_sticky", 64'(ERR_stray), 64'd1);
        handshake();

        // Blocks 6/7: back-to-back, first result held until second completes
        start_block();
        beats(64, 32'd7);
        expect_result("b2b_first", 38'd448, 32'd7);
        handshake();
        start_block();
        beats(32, 32'd1);
        check("b2b_hold_sum", 64'(RESULT_sum), 64'd448);
        check("b2b_hold_max", 64'(RESULT_max), 64'd7);
        beats(32, 32'd1);
        expect_result("b2b_second", 38'd64, 32'd1);
        handshake();
        check("err_still_set", 64'(ERR_stray), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/block_accumulator.md
Name: block_accumulator

Overview:
- Consumer stage directly downstream of the product-buffer multiplier.
- On a START command, it requests a block read (EN_blockRead) and takes in the stream of DEPTH products (VALID_memVal / memVal_data).
- It computes the unsigned sum and maximum of the block.
- It presents the result through a valid/ready handshake to the next stage.

Parameters:
- N, 32, product data width; matches multiplier memory word width.
- DEPTH, 64, products per block; must be a power of two, ≥2.
- ACC_W, N+$clog2(DEPTH) (38), sum width; sized so the sum cannot overflow.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  reset; asynchronous, active-low.
- START  in  1  one-cycle command to begin a block; sampled only in IDLE.
- EN_blockRead  out  1  block-read request to multiplier.
- VALID_memVal  in  1  memVal_data carries a product this cycle.
- memVal_data  in  N  product word, unsigned.
- VALID_result  out  1  result registers valid.
- RDY_result  in  1  downstream accepts result when high with VALID_result.
- RESULT_sum  out  ACC_W  unsigned sum of DEPTH products.
- RESULT_max  out  N  largest product in block.
- BUSY  out  1  high in any state other than IDLE.
- ERR_stray  out  1  sticky: a VALID_memVal beat arrived while not in REQ/ACCUM.

Behaviour:
- Reset (RST_N low, async):
  - State = IDLE.
  - EN_blockRead, VALID_result, BUSY, ERR_stray = 0.
  - RESULT_sum, RESULT_max = 0.
  - Beat counter, accumulator and running max = 0.
  - Reset mid-block abandons the block; no partial result is ever presented.
- State machine: IDLE, REQ, ACCUM, HOLD.
  - IDLE:
    - Outputs low except held RESULT_*.
    - START=1 → REQ.
    - Clears accumulator, running max and counter on that edge.
  - REQ:
    - EN_blockRead=1 (Moore, registered state).
    - Held until the first VALID_memVal beat.
    - That beat is accumulated, counter=1 → ACCUM.
    - DEPTH=1 is not supported.
  - ACCUM:
    - EN_blockRead=1.
    - Each VALID_memVal beat: acc += zero-extended memVal_data; max = larger of max and data (unsigned); counter++.
    - Cycles with VALID_memVal=0 are gaps; state is held, nothing counted.
    - When the beat arrives with counter==DEPTH-1: final sum and max (including that beat) load into RESULT_sum/RESULT_max → HOLD.
  - HOLD:
    - EN_blockRead=0, VALID_result=1.
    - RESULT_* stable while VALID_result && !RDY_result.
    - Handshake completes on the edge where VALID_result && RDY_result → IDLE, VALID_result=0.
    - RESULT_* retain their values after leaving HOLD until the next block completes.
- Latency:
  - START edge → EN_blockRead high the next cycle.
  - Last beat at edge t → VALID_result high after edge t (visible cycle t+1).
  - RDY_result sampled in the same cycle as VALID_result; minimum HOLD duration is 1 cycle.
- START outside IDLE: ignored, no queuing.
- ERR_stray:
  - Set when VALID_memVal=1 in IDLE or HOLD.
  - Clears only on reset.
  - The stray beat is not accumulated.
- Simultaneous START and a stray beat in IDLE: START is honoured and ERR_stray is set.
- Counter: $clog2(DEPTH) bits; never wraps within a block because the block closes at DEPTH beats.
- Arithmetic:
  - Everything is unsigned.
  - Accumulator is ACC_W bits; the maximum value DEPTH*(2^N-1) fits exactly.

Test Plan:
- Reset, then START, then 64 contiguous beats with data 1..64 → EN_blockRead high from cycle after START through last beat; VALID_result next cycle with RESULT_sum=2080, RESULT_max=64.
- 64 beats all 0xFFFFFFFF → RESULT_sum=0x3F_FFFF_FFC0, RESULT_max=0xFFFFFFFF; no overflow.
- Beats 5,3,9,... with random 1–4 cycle gaps (VALID low), RDY_result held low 10 cycles → sum/max correct; RESULT_* and VALID_result stable all 10 cycles; IDLE one cycle after RDY_result=1.
- Assert RST_N low asynchronously after 30 beats (between clock edges) → all outputs 0 immediately; a new START then 64 beats of value 2 → RESULT_sum=128, RESULT_max=2 (no residue from the aborted block).
- VALID_memVal pulse in IDLE, and START pulses during ACCUM → ERR_stray=1 and stays 1; block count unaffected, still exactly 64 beats summed.
- Two back-to-back blocks (START the cycle after the handshake), data 7 then data 1 → second RESULT_sum=64, RESULT_max=1; first result held until second completes.
